tx_frame_ser: RTL

Transmit frame serializer sitting directly downstream of the TX CRC-8 stage. It accepts one parallel frame of payload data and CRC, optionally prepended with a sync header, and shifts it out MSB-first as a 1-bit stream toward the SerDes TX lane. Consecutive frames are separated by a programmable inter-frame gap. Frames offered while the serializer is busy are dropped and counted.

---
 rtl/tx_frame_ser_pkg.sv | 25 ++
 rtl/tx_ser_shreg.sv | 38 +++
 rtl/tx_frame_ser.sv | 138 +++++++++++++
 3 files changed

// File: rtl/tx_frame_ser_pkg.sv
// Shared constants for the TX frame serializer: field widths, sync header and frame-length derivation.
// The sync header is only part of the frame when TX_FRAME_SYNC_HDR_EN is defined.
package tx_frame_ser_pkg;

  localparam int DFLT_DATA_LENGTH = 64;
  localparam int DFLT_CRC_LENGTH  = 8;
  localparam int DFLT_IFG_CYCLES  = 2;

  localparam int         SYNC_LENGTH = 8;
  localparam logic [7:0] SYNC_WORD   = 8'hA5;

`ifdef TX_FRAME_SYNC_HDR_EN
  localparam int SYNC_HDR_LEN = SYNC_LENGTH;
`else
  localparam int SYNC_HDR_LEN = 0;
`endif

  typedef logic [7:0] drop_cnt_t;

  // Total serialized bits per frame: optional header, payload, CRC.
  function automatic int frame_len(input int data_len, input int crc_len);
    return SYNC_HDR_LEN + data_len + crc_len;
  endfunction

endpackage

// File: rtl/tx_ser_shreg.sv
// Parallel-load, MSB-first shift register; zeros enter at the LSB so the
// serial output returns to 0 once the loaded word has been fully shifted out.
module tx_ser_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sh_reg;
  logic [WIDTH-1:0] sh_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign sh_next[gi] = load ? din[gi] : (shift ? 1'b0 : sh_reg[gi]);
      end else begin : g_upper
        assign sh_next[gi] = load ? din[gi] : (shift ? sh_reg[gi-1] : sh_reg[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_reg <= '0;
    end else begin
      sh_reg <= sh_next;
    end
  end

  assign msb = sh_reg[WIDTH-1];

endmodule

// File: rtl/tx_frame_ser.sv
// TX frame serializer: accepts one {sync?, payload, CRC} frame, shifts it out MSB-first,
// then idles IFG_CYCLES cycles. Sync header compiled in by TX_FRAME_SYNC_HDR_EN.
module tx_frame_ser
  import tx_frame_ser_pkg::*;
#(
  parameter int DATA_LENGTH = DFLT_DATA_LENGTH,
  parameter int CRC_LENGTH  = DFLT_CRC_LENGTH,
  parameter int IFG_CYCLES  = DFLT_IFG_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_LENGTH-1:0] frm_data_i,
  input  logic [CRC_LENGTH-1:0]  frm_crc_i,
  input  logic                   frm_vld_i,
  output logic                   frm_rdy_o,
  output logic                   ser_dat_o,
  output logic                   ser_vld_o,
  output logic                   ser_sof_o,
  output logic                   ser_eof_o,
  output logic                   frm_drop_o,
  output logic [7:0]             drop_cnt_o
);

  localparam int FRAME_LEN = frame_len(DATA_LENGTH, CRC_LENGTH);
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int GAP_W     = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int GAP_LAST  = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(FRAME_LEN - 2);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             vld_reg, sof_reg, eof_reg, drop_reg;
  drop_cnt_t        drop_cnt_reg;

  logic [FRAME_LEN-1:0] frame_vec;
  logic accept, shift_en, last_bit, gap_done, drop_evt, eof_next;

`ifdef TX_FRAME_SYNC_HDR_EN
  assign frame_vec = {SYNC_WORD, frm_data_i, frm_crc_i};
`else
  assign frame_vec = {frm_data_i, frm_crc_i};
`endif

  assign last_bit = (bit_cnt_reg == LAST_IDX);
  assign gap_done = (gap_cnt_reg == GAP_W'(GAP_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (frm_vld_i) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = (IFG_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    frm_rdy_o = (state_reg == IDLE);
    accept    = frm_rdy_o && frm_vld_i;
    drop_evt  = !frm_rdy_o && frm_vld_i;
    shift_en  = (state_reg == SHIFT);
    eof_next  = shift_en && (bit_cnt_reg == PRE_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
    end else begin
      if (accept) begin
        bit_cnt_reg <= '0;
      end else if (shift_en && !last_bit) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
      if (shift_en) begin
        gap_cnt_reg <= '0;
      end else if ((state_reg == GAP) && !gap_done) begin
        gap_cnt_reg <= gap_cnt_reg + 1'b1;
      end
    end
  end

  // Frame flags are registered alongside the shift register so they line up with ser_dat_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_reg      <= 1'b0;
      sof_reg      <= 1'b0;
      eof_reg      <= 1'b0;
      drop_reg     <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      if (accept) begin
        vld_reg <= 1'b1;
      end else if (shift_en && last_bit) begin
        vld_reg <= 1'b0;
      end
      sof_reg  <= accept;
      eof_reg  <= eof_next;
      drop_reg <= drop_evt;
      if (drop_evt && (drop_cnt_reg != 8'hFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
    end
  end

  tx_ser_shreg #(
    .WIDTH (FRAME_LEN)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shift_en),
    .din   (frame_vec),
    .msb   (ser_dat_o)
  );

  assign ser_vld_o  = vld_reg;
  assign ser_sof_o  = sof_reg;
  assign ser_eof_o  = eof_reg;
  assign frm_drop_o = drop_reg;
  assign drop_cnt_o = drop_cnt_reg;

endmodule
